// File: rtl/dog_stack.sv
// Difference-of-Gaussian stack: streams one octave of blurred images at one pixel
// per cycle and writes all NUM_SCALES-1 DoG layers plus per-layer peak |DoG|.

module dog_stack_lane #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] i_fine,
  input  logic [PW-1:0] i_coarse,
  input  logic          i_cap,
  input  logic          i_upd,
  input  logic          i_clr,
  output logic [PW:0]   o_dog,
  output logic [PW-1:0] o_peak
);
  logic [PW:0]   r_dog;
  logic [PW-1:0] r_peak;
  logic [PW:0]   w_mag;
  logic [PW-1:0] w_abs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_dog <= '0;
    else if (i_cap) r_dog <= {1'b0, i_coarse} - {1'b0, i_fine};
  end

  // Only -2^PW could overflow the magnitude; clamp it defensively.
  always_comb begin
    w_mag = r_dog[PW] ? -r_dog : r_dog;
    w_abs = w_mag[PW] ? '1 : w_mag[PW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_peak <= '0;
    else if (i_clr)                   r_peak <= '0;
    else if (i_upd && w_abs > r_peak) r_peak <= w_abs;
  end

  assign o_dog  = r_dog;
  assign o_peak = r_peak;
endmodule

module dog_stack #(
  parameter int DIMENSION    = 64,
  parameter int PIX_WIDTH    = 8,
  parameter int NUM_SCALES   = 4,
  parameter int BRAM_LATENCY = 2,
  parameter int ADDR_WIDTH   = $clog2(DIMENSION*DIMENSION)
) (
  input  logic                                      clk,
  input  logic                                      rst_in,
  input  logic                                      start,
  input  logic [NUM_SCALES*PIX_WIDTH-1:0]           blur_pix,
  output logic [ADDR_WIDTH-1:0]                     read_addr,
  output logic [ADDR_WIDTH-1:0]                     write_addr,
  output logic [(NUM_SCALES-1)*(PIX_WIDTH+1)-1:0]   dog_out,
  output logic                                      wea,
  output logic                                      busy,
  output logic                                      done,
  output logic [(NUM_SCALES-1)*PIX_WIDTH-1:0]       peak_abs,
  output logic [1:0]                                state_num
);
  localparam int L    = NUM_SCALES - 1;
  localparam int DW   = PIX_WIDTH + 1;
  localparam int NPIX = DIMENSION * DIMENSION;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NPIX - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                                   r_state, w_next;
  logic                                     w_accept, w_issue;
  logic [ADDR_WIDTH-1:0]                    r_read_addr;
  logic [BRAM_LATENCY:0]                    r_vld_pipe;
  logic [BRAM_LATENCY:0][ADDR_WIDTH-1:0]    r_addr_pipe;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE:  if (start) begin w_next = READ; w_accept = 1'b1; end
      READ:  if (r_read_addr == LAST) w_next = DRAIN;
      DRAIN: if (wea && write_addr == LAST) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_issue = (r_state == READ);

  // Address saturates at LAST and is held outside READ.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in)                              r_read_addr <= '0;
    else if (w_accept)                       r_read_addr <= '0;
    else if (w_issue && r_read_addr != LAST) r_read_addr <= r_read_addr + ADDR_WIDTH'(1);
  end

  // Stage BRAM_LATENCY-1 lines up with valid blur data; the tail drives the write.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[BRAM_LATENCY-1:0], w_issue};
      r_addr_pipe <= {r_addr_pipe[BRAM_LATENCY-1:0], r_read_addr};
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lane
    dog_stack_lane #(.PW(PIX_WIDTH)) u_lane (
      .clk      (clk),
      .rst      (rst_in),
      .i_fine   (blur_pix[k*PIX_WIDTH +: PIX_WIDTH]),
      .i_coarse (blur_pix[(k+1)*PIX_WIDTH +: PIX_WIDTH]),
      .i_cap    (r_vld_pipe[BRAM_LATENCY-1]),
      .i_upd    (r_vld_pipe[BRAM_LATENCY]),
      .i_clr    (w_accept),
      .o_dog    (dog_out[k*DW +: DW]),
      .o_peak   (peak_abs[k*PIX_WIDTH +: PIX_WIDTH])
    );
  end

  assign read_addr  = r_read_addr;
  assign write_addr = r_addr_pipe[BRAM_LATENCY];
  assign wea        = r_vld_pipe[BRAM_LATENCY];
  assign busy       = (r_state == READ) || (r_state == DRAIN);
  assign done       = (r_state == DONE);
  assign state_num  = r_state;
endmodule

// File: tb/tb_dog_stack.sv
// Directed bench for dog_stack: 4x4/3-scale/latency-2 instance plus an
// 8x8/latency-1 instance, with a small delayed-address BRAM model.

module tb_dog_stack;
  logic        clk = 1'b0;
  logic        rst_in;
  logic        start, b_start;
  int          mode;
  logic [23:0] cblur;

  logic [23:0] blur_a;
  logic [3:0]  read_addr, write_addr, a_d1, a_d2;
  logic [17:0] dog_out;
  logic        wea, busy, done;
  logic [15:0] peak_abs;
  logic [1:0]  state_num;

  logic [5:0]  b_read_addr, b_write_addr;
  logic [17:0] b_dog_out;
  logic        b_wea, b_busy, b_done;
  logic [15:0] b_peak_abs;
  logic [1:0]  b_state_num;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_d1 <= read_addr;
    a_d2 <= a_d1;
  end

  assign blur_a = (mode == 1) ? {8'(a_d2 * 3), 8'(a_d2 * 2), 8'(a_d2)} : cblur;

  dog_stack #(.DIMENSION(4), .PIX_WIDTH(8), .NUM_SCALES(3), .BRAM_LATENCY(2)) u_a (
    .clk(clk), .rst_in(rst_in), .start(start), .blur_pix(blur_a),
    .read_addr(read_addr), .write_addr(write_addr), .dog_out(dog_out), .wea(wea),
    .busy(busy), .done(done), .peak_abs(peak_abs), .state_num(state_num));

  dog_stack #(.DIMENSION(8), .PIX_WIDTH(8), .NUM_SCALES(3), .BRAM_LATENCY(1)) u_b (
    .clk(clk), .rst_in(rst_in), .start(b_start), .blur_pix(24'h2A170A),
    .read_addr(b_read_addr), .write_addr(b_write_addr), .dog_out(b_dog_out), .wea(b_wea),
    .busy(b_busy), .done(b_done), .peak_abs(b_peak_abs), .state_num(b_state_num));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_pass(input string tg, input int md, input int e0, input int e1,
                          input int p0, input int p1, input bit mid, input bit ondone,
                          input int rst_at);
    int cyc, nwr, first, dcyc, ndone, stray;
    cyc = 0; nwr = 0; first = -1; dcyc = -1; ndone = 0; stray = 0;
    mode = md;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tg, ":busy_on"}, busy, 1);
    chk({tg, ":raddr0"}, read_addr, 0);
    while (cyc < 60) begin
      @(negedge clk); cyc++;
      start = 1'b0;
      if (wea) begin
        if (first < 0) first = cyc;
        chk({tg, ":waddr"}, write_addr, nwr);
        chk({tg, ":dog0"}, $signed(dog_out[8:0]), (md == 1) ? nwr : e0);
        chk({tg, ":dog1"}, $signed(dog_out[17:9]), (md == 1) ? nwr : e1);
        nwr++;
        if (rst_at != 0 && nwr == rst_at) begin
          rst_in = 1'b1; #1;
          chk({tg, ":rst_wea"}, wea, 0);
          chk({tg, ":rst_busy"}, busy, 0);
          chk({tg, ":rst_state"}, state_num, 0);
          repeat (2) @(negedge clk);
          rst_in = 1'b0;
          repeat (6) begin
            @(negedge clk);
            if (wea) stray++;
          end
          chk({tg, ":no_writes_after_rst"}, stray, 0);
          return;
        end
      end
      if (done) begin
        ndone++; dcyc = cyc;
        chk({tg, ":busy_at_done"}, busy, 0);
        chk({tg, ":peak0"}, peak_abs[7:0], p0);
        chk({tg, ":peak1"}, peak_abs[15:8], p1);
        if (ondone) start = 1'b1;
        break;
      end
      if (mid && cyc == 8) start = 1'b1;
    end
    chk({tg, ":writes"}, nwr, 16);
    chk({tg, ":first_wea"}, first, 4);
    chk({tg, ":done_cyc"}, dcyc, 20);
    chk({tg, ":done_cnt"}, ndone, 1);
    @(posedge clk); #1 start = 1'b0;
    chk({tg, ":idle_after"}, state_num, 0);
    chk({tg, ":done_pulse"}, done, 0);
    chk({tg, ":raddr_hold"}, read_addr, 15);
  endtask

  initial begin
    int cyc, nwr, first, dcyc;
    rst_in = 1'b1; start = 1'b0; b_start = 1'b0; mode = 0; cblur = 24'h0;
    repeat (2) @(negedge clk);
    chk("rst:wea", wea, 0);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:raddr", read_addr, 0);
    chk("rst:waddr", write_addr, 0);
    chk("rst:dog", dog_out, 0);
    chk("rst:peak", peak_abs, 0);
    chk("rst:state", state_num, 0);
    rst_in = 1'b0;
    repeat (2) @(negedge clk);

    cblur = {8'd42, 8'd23, 8'd10};
    run_pass("t1", 0, 13, 19, 13, 19, 1'b0, 1'b0, 0);
    run_pass("t2", 1, 0, 0, 15, 15, 1'b0, 1'b0, 0);
    cblur = {8'd0, 8'd200, 8'd255};
    run_pass("t3", 0, -55, -200, 55, 200, 1'b0, 1'b0, 0);
    cblur = {8'd42, 8'd23, 8'd10};
    run_pass("t4", 0, 13, 19, 13, 19, 1'b1, 1'b1, 0);
    cblur = {8'd5, 8'd4, 8'd3};
    run_pass("t4b", 0, 1, 1, 1, 1, 1'b0, 1'b0, 0);
    cblur = {8'd42, 8'd23, 8'd10};
    run_pass("t5", 0, 13, 19, 13, 19, 1'b0, 1'b0, 7);
    run_pass("t5b", 0, 13, 19, 13, 19, 1'b0, 1'b0, 0);

    cyc = 0; nwr = 0; first = -1; dcyc = -1;
    @(negedge clk); b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    while (cyc < 120) begin
      @(negedge clk); cyc++;
      if (b_wea) begin
        if (first < 0) first = cyc;
        chk("t6:waddr", b_write_addr, nwr);
        nwr++;
      end
      if (b_done) begin dcyc = cyc; break; end
    end
    chk("t6:writes", nwr, 64);
    chk("t6:first_wea", first, 3);
    chk("t6:done_cyc", dcyc, 67);
    chk("t6:dog0", $signed(b_dog_out[8:0]), 13);
    chk("t6:peak1", b_peak_abs[15:8], 19);
    chk("t6:raddr_hold", b_read_addr, 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
